// File: rtl/fdl_ctrl.sv
// Fine-delay-line controller: filters PD up/down votes, steps a 0..6 thermometer level, wraps into the coarse stage.
// Latency: Q/ovf/unf/locked update on the edge that samples the FILT_LEN-th net vote; all outputs are registered.
// Backpressure: none; pd_valid is ignored while idle or settling, and en=0 holds Q and clears filter/lock state.
module fdl_ctrl #(
  parameter int FILT_LEN = 4,
  parameter int SETTLE   = 2,
  parameter int LOCK_CNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pd_valid,
  input  logic       pd_up,
  input  logic       pd_dn,
  output logic [5:0] Q,
  output logic       ovf,
  output logic       unf,
  output logic       locked
);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_SETTLE} state_t;

  // The accumulator never holds +/-FILT_LEN: reaching it steps and clears in one update.
  localparam logic signed [4:0] ACC_HI   = 5'(FILT_LEN - 1);
  localparam logic signed [4:0] ACC_LO   = 5'(1 - FILT_LEN);
  localparam logic [4:0]        REV_MAX  = 5'(LOCK_CNT);
  localparam logic [3:0]        SET_LOAD = 4'(SETTLE - 1);
  localparam logic [2:0]        LVL_MAX  = 3'd6;

  state_t             state;
  logic [2:0]         lvl;
  logic signed [4:0]  acc;
  logic [4:0]         rev;
  logic               prev_vld;
  logic               prev_up;
  logic [3:0]         settle_cnt;

  logic               vote_up;
  logic               vote_dn;
  logic signed [4:0]  acc_nxt;
  logic               step_up;
  logic               step_dn;
  logic [2:0]         lvl_nxt;
  logic               wrap_ovf;
  logic               wrap_unf;
  logic [4:0]         rev_nxt;

  // Thermometer code, MSB-first fill: bit 5-i is set when the level exceeds i.
  function automatic logic [5:0] therm(input logic [2:0] l);
    logic [5:0] q;
    q = '0;
    for (int i = 0; i < 6; i++) begin
      q[5-i] = (l > 3'(i));
    end
    return q;
  endfunction

  assign vote_up = pd_valid & pd_up & ~pd_dn;
  assign vote_dn = pd_valid & pd_dn & ~pd_up;

  // Vote filter: only counts while tracking; saturating count triggers a step and clears.
  always_comb begin
    acc_nxt = acc;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (state == S_TRACK) begin
      if (vote_up) begin
        if (acc == ACC_HI) begin
          step_up = 1'b1;
          acc_nxt = '0;
        end else begin
          acc_nxt = acc + 5'sd1;
        end
      end else if (vote_dn) begin
        if (acc == ACC_LO) begin
          step_dn = 1'b1;
          acc_nxt = '0;
        end else begin
          acc_nxt = acc - 5'sd1;
        end
      end
    end
  end

  // Level update with wrap-around into the coarse stage (one coarse unit = 7 fine steps).
  always_comb begin
    lvl_nxt  = lvl;
    wrap_ovf = 1'b0;
    wrap_unf = 1'b0;
    if (step_up) begin
      if (lvl == LVL_MAX) begin
        lvl_nxt  = '0;
        wrap_ovf = 1'b1;
      end else begin
        lvl_nxt = lvl + 3'd1;
      end
    end else if (step_dn) begin
      if (lvl == '0) begin
        lvl_nxt  = LVL_MAX;
        wrap_unf = 1'b1;
      end else begin
        lvl_nxt = lvl - 3'd1;
      end
    end
  end

  // Reversal counter: opposite-direction steps count up (saturating), repeats and wraps reset it,
  // and the first step after idle only records its direction.
  always_comb begin
    rev_nxt = rev;
    if (step_up || step_dn) begin
      if (wrap_ovf || wrap_unf) begin
        rev_nxt = '0;
      end else if (prev_vld) begin
        if (step_up != prev_up) begin
          rev_nxt = (rev == REV_MAX) ? rev : rev + 5'd1;
        end else begin
          rev_nxt = '0;
        end
      end
    end
  end

  // Control FSM and all registered outputs; en=0 overrides any pending step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lvl        <= 3'd3;
      Q          <= 6'b111000;
      acc        <= '0;
      rev        <= '0;
      prev_vld   <= 1'b0;
      prev_up    <= 1'b0;
      settle_cnt <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      locked     <= 1'b0;
    end else if (!en) begin
      state      <= S_IDLE;
      acc        <= '0;
      rev        <= '0;
      prev_vld   <= 1'b0;
      settle_cnt <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      locked     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ovf   <= 1'b0;
          unf   <= 1'b0;
          acc   <= '0;
          state <= S_TRACK;
        end
        S_TRACK: begin
          acc <= acc_nxt;
          lvl <= lvl_nxt;
          Q   <= therm(lvl_nxt);
          ovf <= wrap_ovf;
          unf <= wrap_unf;
          if (step_up || step_dn) begin
            state      <= S_SETTLE;
            settle_cnt <= SET_LOAD;
            prev_vld   <= 1'b1;
            prev_up    <= step_up;
            rev        <= rev_nxt;
            locked     <= (rev_nxt == REV_MAX);
          end
        end
        S_SETTLE: begin
          ovf <= 1'b0;
          unf <= 1'b0;
          acc <= '0;
          if (settle_cnt == '0) begin
            state <= S_TRACK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
